// File: rtl/gpio_pkg.sv
// Shared GPIO bank definitions: CSR register offsets relative to BASE_ADDR and the per-instance pin limit.
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 8;

  localparam logic [4:0] GPIO_DIR   = 5'd0;
  localparam logic [4:0] GPIO_OUT   = 5'd1;
  localparam logic [4:0] GPIO_IN    = 5'd2;
  localparam logic [4:0] GPIO_IE    = 5'd3;
  localparam logic [4:0] GPIO_IP    = 5'd4;
  localparam logic [4:0] GPIO_IEDGE = 5'd5;
  localparam logic [4:0] GPIO_NUM_REGS = 5'd6;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchroniser, parametrised width, synchronous active-high reset.
// Latency: an input change sampled at edge k appears on q after edge k+1; no backpressure.
module gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/gpio.sv
// GPIO bank on the 5-bit/8-bit CSR bus: DIR/OUT/IN, plus IE/IP/IEDGE edge interrupts when GPIO_IRQ_EN is defined.
// Writes land on the csr_we edge, reads are combinational, IN lags pins by two edges; no backpressure.
module gpio #(
  parameter logic [4:0] BASE_ADDR = 5'h00,
  parameter int         NUM_GPIOS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           csr_a,
  input  logic [7:0]           csr_di,
  input  logic                 csr_we,
  output logic [7:0]           csr_do,
  input  logic [NUM_GPIOS-1:0] gpio_in,
  output logic [NUM_GPIOS-1:0] gpio_out,
  output logic [NUM_GPIOS-1:0] gpio_oe,
  output logic                 irq
);

  import gpio_pkg::*;

  localparam int N = NUM_GPIOS;

  // Wraps to a large value for addresses below BASE_ADDR, so one compare covers both ends.
  logic [4:0]   offset;
  logic         hit;
  logic [N-1:0] wdat;
  logic [N-1:0] in_sync;
  logic [N-1:0] rdat;

  assign offset = csr_a - BASE_ADDR;
  assign hit    = offset < GPIO_NUM_REGS;
  assign wdat   = csr_di[N-1:0];

  gpio_sync #(.WIDTH(N)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_in),
    .q   (in_sync)
  );

  logic [N-1:0] dir_q, dir_d;
  logic [N-1:0] out_q, out_d;

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (csr_we && offset == GPIO_DIR) dir_d = wdat;
    if (csr_we && offset == GPIO_OUT) out_d = wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= '0;
      out_q <= '0;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

  assign gpio_oe  = dir_q;
  assign gpio_out = out_q;

`ifdef GPIO_IRQ_EN
  logic [N-1:0] ie_q, ie_d;
  logic [N-1:0] ip_q, ip_d;
  logic [N-1:0] iedge_q, iedge_d;
  logic [N-1:0] prev_q, prev_d;
  logic [1:0]   arm_q, arm_d;
  logic         armed;
  logic [N-1:0] evt;

  // Armed only once prev holds a real pin sample, so a pin high at reset raises nothing.
  always_comb begin
    armed   = arm_q == 2'd3;
    arm_d   = armed ? arm_q : arm_q + 2'd1;
    prev_d  = in_sync;
    evt     = armed ? ((in_sync ^ prev_q) & ~(in_sync ^ iedge_q)) : '0;
    ie_d    = ie_q;
    iedge_d = iedge_q;
    ip_d    = ip_q;
    if (csr_we && offset == GPIO_IE)    ie_d    = wdat;
    if (csr_we && offset == GPIO_IEDGE) iedge_d = wdat;
    if (csr_we && offset == GPIO_IP)    ip_d    = ip_q & ~wdat;
    ip_d = ip_d | evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q    <= '0;
      ip_q    <= '0;
      iedge_q <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
    end else begin
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      iedge_q <= iedge_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
    end
  end

  assign irq = |(ip_q & ie_q);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdat = '0;
    if (hit) begin
      case (offset)
        GPIO_DIR:   rdat = dir_q;
        GPIO_OUT:   rdat = out_q;
        GPIO_IN:    rdat = in_sync;
`ifdef GPIO_IRQ_EN
        GPIO_IE:    rdat = ie_q;
        GPIO_IP:    rdat = ip_q;
        GPIO_IEDGE: rdat = iedge_q;
`endif
        default:    rdat = '0;
      endcase
    end
    csr_do         = '0;
    csr_do[N-1:0]  = rdat;
  end

endmodule

// File: tb/tb_gpio.sv
// Directed bench for gpio: an 8-pin bank at 5'h00 and a 3-pin bank at 5'h08 sharing one CSR bus.
module tb_gpio;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do, csr_do3;
  logic [7:0] gpio_in, gpio_out, gpio_oe;
  logic [2:0] gpio_in3, gpio_out3, gpio_oe3;
  logic       irq, irq3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio #(.BASE_ADDR(5'h00), .NUM_GPIOS(8)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio #(.BASE_ADDR(5'h08), .NUM_GPIOS(3)) dut3 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do3), .gpio_in(gpio_in3), .gpio_out(gpio_out3), .gpio_oe(gpio_oe3), .irq(irq3)
  );

  typedef struct {
    logic       we;
    logic [4:0] a;
    logic [7:0] di;
    logic [7:0] exp_do;
    logic [7:0] exp_oe;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [4:0] a, input logic [7:0] di,
                              input logic [7:0] exp_do, input logic [7:0] exp_oe,
                              input logic [7:0] exp_out);
    vec_t v;
    v.we = we; v.a = a; v.di = di;
    v.exp_do = exp_do; v.exp_oe = exp_oe; v.exp_out = exp_out;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called in the low clock phase; samples after the combinational read settles.
  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(nm, csr_do, exp);
  endtask

  task automatic rd3_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(nm, csr_do3, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ip_or;

    rst = 1'b1; csr_a = '0; csr_di = '0; csr_we = 1'b0;
    gpio_in = 8'h00; gpio_in3 = 3'b000;
    cycles(3);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    rd_chk("rst_in", 5'h02, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) vecs.push_back(mk(1'b0, 5'(i), 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 5'h06, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1'b0, 5'h1F, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(1'b1, 5'h00, 8'hF0, 8'hF0, 8'hF0, 8'h00));
    vecs.push_back(mk(1'b1, 5'h01, 8'hA5, 8'hA5, 8'hF0, 8'hA5));
    vecs.push_back(mk(1'b1, 5'h02, 8'h55, 8'h00, 8'hF0, 8'hA5));
    vecs.push_back(mk(1'b1, 5'h00, 8'h00, 8'h00, 8'h00, 8'hA5));
    vecs.push_back(mk(1'b1, 5'h03, 8'h3C, IRQ ? 8'h3C : 8'h00, 8'h00, 8'hA5));
    vecs.push_back(mk(1'b1, 5'h05, 8'h81, IRQ ? 8'h81 : 8'h00, 8'h00, 8'hA5));
    vecs.push_back(mk(1'b1, 5'h04, 8'hFF, 8'h00, 8'h00, 8'hA5));
    vecs.push_back(mk(1'b1, 5'h06, 8'hFF, 8'h00, 8'h00, 8'hA5));

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].a, vecs[i].di);
      rd_chk($sformatf("vec%0d_do", i), vecs[i].a, vecs[i].exp_do);
      chk($sformatf("vec%0d_oe", i), gpio_oe, vecs[i].exp_oe);
      chk($sformatf("vec%0d_out", i), gpio_out, vecs[i].exp_out);
    end
    chk("irq_idle", {7'd0, irq}, 8'h00);
    chk("bank3_untouched", {5'd0, gpio_out3}, 8'h00);

    // Rising edge on pin 3: IN after k+1, IP and irq at k+2, then W1C.
    wr(5'h03, 8'h08);
    wr(5'h05, 8'h08);
    gpio_in = 8'h08;
    cycles(1);
    rd_chk("lat_in_k", 5'h02, 8'h00);
    cycles(1);
    rd_chk("lat_in_k1", 5'h02, 8'h08);
    rd_chk("lat_ip_k1", 5'h04, 8'h00);
    chk("lat_irq_k1", {7'd0, irq}, 8'h00);
    cycles(1);
    rd_chk("lat_ip_k2", 5'h04, IRQ ? 8'h08 : 8'h00);
    chk("lat_irq_k2", {7'd0, irq}, {7'd0, IRQ});
    wr(5'h04, 8'h08);
    rd_chk("w1c_ip", 5'h04, 8'h00);
    chk("w1c_irq", {7'd0, irq}, 8'h00);

    // Falling edge ignored while IEDGE selects rising; then falling mode.
    gpio_in = 8'h00;
    cycles(4);
    rd_chk("fall_ignored", 5'h04, 8'h00);
    wr(5'h05, 8'h00);
    gpio_in = 8'h08;
    cycles(4);
    rd_chk("rise_ignored", 5'h04, 8'h00);
    gpio_in = 8'h00;
    cycles(4);
    rd_chk("fall_sets", 5'h04, IRQ ? 8'h08 : 8'h00);

    // Reset with pins high clears pending state and raises no spurious edge.
    gpio_in = 8'hFF;
    rst = 1'b1;
    cycles(2);
    rd_chk("rst_ip_clear", 5'h04, 8'h00);
    chk("rst_irq_clear", {7'd0, irq}, 8'h00);
    chk("rst_out_clear", gpio_out, 8'h00);
    rst = 1'b0;
    ip_or = 8'h00;
    for (int c = 0; c < 20; c++) begin
      cycles(1);
      csr_a = 5'h04;
      #1;
      ip_or = ip_or | csr_do;
    end
    chk("no_spurious_ip", ip_or, 8'h00);
    rd_chk("in_all_high", 5'h02, 8'hFF);

    // W1C of IP[0] on the same edge that a new rising event lands: set wins.
    wr(5'h05, 8'h01);
    wr(5'h03, 8'h01);
    gpio_in = 8'hFE;
    cycles(4);
    rd_chk("pin0_fall_ignored", 5'h04, 8'h00);
    gpio_in = 8'hFF;
    cycles(2);
    wr(5'h04, 8'h01);
    rd_chk("w1c_vs_set", 5'h04, IRQ ? 8'h01 : 8'h00);
    chk("w1c_vs_set_irq", {7'd0, irq}, {7'd0, IRQ});
    wr(5'h04, 8'h01);
    rd_chk("w1c_after", 5'h04, 8'h00);

    // Narrow bank at 5'h08: upper bits read as zero, other bank reads zero.
    wr(5'h09, 8'hFF);
    rd3_chk("b3_out_rd", 5'h09, 8'h07);
    chk("b3_out_pins", {5'd0, gpio_out3}, 8'h07);
    rd_chk("b0_unmapped", 5'h09, 8'h00);
    wr(5'h08, 8'hFF);
    rd3_chk("b3_dir_rd", 5'h08, 8'h07);
    chk("b3_oe_pins", {5'd0, gpio_oe3}, 8'h07);
    gpio_in3 = 3'b101;
    cycles(2);
    rd3_chk("b3_in_rd", 5'h0A, 8'h05);
    rd3_chk("b3_base0_rd", 5'h01, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
